// File: rtl/alk_pkg.sv
// Shared definitions for the ALK WBUS flag/loop load block: the loop state
// encoding, the loop counter width and the WBUS flag bit positions.
package alk_pkg;

  localparam int LOOP_CNT_W   = 6;
  localparam int WB_ALUSO_BIT = 31;
  localparam int WB_ALKC_BIT  = 30;

  typedef enum logic [1:0] {
    LOOP_IDLE = 2'd0,
    LOOP_RUN  = 2'd1,
    LOOP_DONE = 2'd2
  } loop_state_t;

  typedef logic [LOOP_CNT_W-1:0] loop_cnt_t;

endpackage

// File: rtl/alk_loop_ctr.sv
// Loop iteration down-counter and its IDLE/RUN/DONE sequencing FSM.
//   state     | meaning
//   LOOP_IDLE | no loop loaded since reset; steps are ignored
//   LOOP_RUN  | iterations remaining (cnt > 0); each step decrements
//   LOOP_DONE | count exhausted, cnt held at 0 until the next load
module alk_loop_ctr
  import alk_pkg::*;
(
  input  logic      clk_h,
  input  logic      reset_l,
  input  logic      load,
  input  loop_cnt_t load_cnt,
  input  logic      step,
  output loop_cnt_t loop_cnt,
  output logic      loop_busy,
  output logic      done_set
);

  loop_state_t state, state_nxt;
  loop_cnt_t   cnt_nxt;
  logic        last_step;

  assign last_step = (state == LOOP_RUN) && step && (loop_cnt <= loop_cnt_t'(1));

  always_ff @(posedge clk_h) begin
    if (!reset_l) begin
      state    <= LOOP_IDLE;
      loop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      loop_cnt <= cnt_nxt;
    end
  end

  // A load always wins over a step arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = loop_cnt;
    if (load) begin
      cnt_nxt   = load_cnt;
      state_nxt = (load_cnt != '0) ? LOOP_RUN : LOOP_DONE;
    end else if (last_step) begin
      cnt_nxt   = '0;
      state_nxt = LOOP_DONE;
    end else if ((state == LOOP_RUN) && step) begin
      cnt_nxt = loop_cnt - loop_cnt_t'(1);
    end
  end

  always_comb begin
    loop_busy = (state == LOOP_RUN);
    done_set  = load ? (load_cnt == '0) : last_step;
  end

endmodule

// File: rtl/alk_wbus_flag_load.sv
// ALK flag registers (carry, shift-out, loop) with WBUS group loads, plus the
// loop counter sub-block.
module alk_wbus_flag_load
  import alk_pkg::*;
(
  input  logic        clk_h,
  input  logic        reset_l,
  input  logic [31:0] wbus_in_h,
  input  logic        alpctl_wb_group_ld,
  input  logic        alpctl_wb_aluf_h,
  input  logic        alpctl_wb_loopf_h,
  input  logic        alu_flag_upd_h,
  input  logic        alu_c_h,
  input  logic        alu_so_h,
  input  logic        loop_step_h,
  output logic        alkc_flag_h,
  output logic        aluso_flag_h,
  output logic        loop_flag_h,
  output logic [5:0]  loop_cnt_h,
  output logic        loop_busy_h
);

  logic      wb_alu_ld, wb_loop_ld, done_set;
  loop_cnt_t loop_cnt;
  logic      wbus_unused;

  assign wb_alu_ld   = alpctl_wb_group_ld & alpctl_wb_aluf_h;
  assign wb_loop_ld  = alpctl_wb_group_ld & alpctl_wb_loopf_h;
  assign wbus_unused = ^wbus_in_h[29:LOOP_CNT_W];

  alk_loop_ctr u_loop_ctr (
    .clk_h     (clk_h),
    .reset_l   (reset_l),
    .load      (wb_loop_ld),
    .load_cnt  (wbus_in_h[LOOP_CNT_W-1:0]),
    .step      (loop_step_h),
    .loop_cnt  (loop_cnt),
    .loop_busy (loop_busy_h),
    .done_set  (done_set)
  );

  assign loop_cnt_h = loop_cnt;

  always_ff @(posedge clk_h) begin
    if (!reset_l) begin
      alkc_flag_h  <= 1'b0;
      aluso_flag_h <= 1'b0;
    end else if (wb_alu_ld) begin
      alkc_flag_h  <= wbus_in_h[WB_ALKC_BIT];
      aluso_flag_h <= wbus_in_h[WB_ALUSO_BIT];
    end else if (alu_flag_upd_h) begin
      alkc_flag_h  <= alu_c_h;
      aluso_flag_h <= alu_so_h;
    end
  end

  // Bit 30 belongs to the ALU flags when both groups load together.
  always_ff @(posedge clk_h) begin
    if (!reset_l) begin
      loop_flag_h <= 1'b0;
    end else if (done_set) begin
      loop_flag_h <= 1'b1;
    end else if (wb_loop_ld) begin
      loop_flag_h <= wb_alu_ld ? 1'b0 : wbus_in_h[WB_ALKC_BIT];
    end
  end

endmodule

// File: tb/tb_alk_wbus_flag_load.sv
// Self-checking bench: directed vector table, hand sequences, and randomized
// traffic checked against a behavioural model of the flag/loop rules.
module tb_alk_wbus_flag_load;

  logic        clk_h = 1'b0;
  logic        reset_l;
  logic [31:0] wbus_in_h;
  logic        alpctl_wb_group_ld, alpctl_wb_aluf_h, alpctl_wb_loopf_h;
  logic        alu_flag_upd_h, alu_c_h, alu_so_h, loop_step_h;
  logic        alkc_flag_h, aluso_flag_h, loop_flag_h, loop_busy_h;
  logic [5:0]  loop_cnt_h;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_h = ~clk_h;

  alk_wbus_flag_load dut (
    .clk_h              (clk_h),
    .reset_l            (reset_l),
    .wbus_in_h          (wbus_in_h),
    .alpctl_wb_group_ld (alpctl_wb_group_ld),
    .alpctl_wb_aluf_h   (alpctl_wb_aluf_h),
    .alpctl_wb_loopf_h  (alpctl_wb_loopf_h),
    .alu_flag_upd_h     (alu_flag_upd_h),
    .alu_c_h            (alu_c_h),
    .alu_so_h           (alu_so_h),
    .loop_step_h        (loop_step_h),
    .alkc_flag_h        (alkc_flag_h),
    .aluso_flag_h       (aluso_flag_h),
    .loop_flag_h        (loop_flag_h),
    .loop_cnt_h         (loop_cnt_h),
    .loop_busy_h        (loop_busy_h)
  );

  typedef struct {
    logic       rst_l, g, af, lf, w31, w30;
    logic [5:0] wcnt;
    logic       upd, c, so, stp;
    logic       e_alkc, e_aluso, e_flag;
    logic [5:0] e_cnt;
    logic       e_busy;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_l, g, af, lf, w31, w30, input logic [5:0] wcnt,
                     input logic upd, c, so, stp,
                     input logic e_alkc, e_aluso, e_flag, input logic [5:0] e_cnt,
                     input logic e_busy, input string name);
    vec_t v;
    v.rst_l = rst_l; v.g = g; v.af = af; v.lf = lf; v.w31 = w31; v.w30 = w30;
    v.wcnt = wcnt; v.upd = upd; v.c = c; v.so = so; v.stp = stp;
    v.e_alkc = e_alkc; v.e_aluso = e_aluso; v.e_flag = e_flag;
    v.e_cnt = e_cnt; v.e_busy = e_busy; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst_l, g, af, lf, w31, w30, input logic [5:0] wcnt,
                       input logic upd, c, so, stp);
    logic [23:0] junk;
    junk = 24'($urandom);
    reset_l = rst_l; alpctl_wb_group_ld = g; alpctl_wb_aluf_h = af;
    alpctl_wb_loopf_h = lf; wbus_in_h = {w31, w30, junk, wcnt};
    alu_flag_upd_h = upd; alu_c_h = c; alu_so_h = so; loop_step_h = stp;
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {alkc,aluso,flag,busy,cnt}=%b required %b", name, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {alkc_flag_h, aluso_flag_h, loop_flag_h, loop_busy_h, loop_cnt_h};
  endfunction

  // Apply one cycle of stimulus, then sample just after the rising edge.
  task automatic cycle_check(input string name, input logic [9:0] exp);
    @(posedge clk_h); #1;
    check(name, outs(), exp);
  endtask

  // Behavioural reference state.
  logic m_alkc, m_aluso, m_flag;
  int   m_cnt;
  bit   m_running;

  task automatic model(input logic rst_l, g, af, lf, w31, w30, input logic [5:0] wcnt,
                       input logic upd, c, so, stp);
    if (!rst_l) begin
      m_alkc = 0; m_aluso = 0; m_flag = 0; m_cnt = 0; m_running = 0;
      return;
    end
    if (g && af) begin m_alkc = w30; m_aluso = w31; end
    else if (upd) begin m_alkc = c; m_aluso = so; end
    if (g && lf) begin
      m_cnt = int'(wcnt);
      m_running = (m_cnt != 0);
      m_flag = (m_cnt == 0) ? 1'b1 : ((g && af) ? 1'b0 : w30);
    end else if (m_running && stp) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_running = 0; m_flag = 1; end
    end
  endtask

  function automatic logic [9:0] m_outs();
    return {m_alkc, m_aluso, m_flag, logic'(m_running), 6'(m_cnt)};
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);

    //   rst g af lf w31 w30 cnt  upd c so stp | alkc aluso flag cnt busy
    add(0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0,   0, 0, 0, 6'd0, 0, "reset");
    add(1, 1, 1, 0, 1, 0, 6'd0, 0, 0, 0, 0,   0, 1, 0, 6'd0, 0, "wb_aluf_10");
    add(1, 1, 1, 0, 0, 0, 6'd0, 1, 1, 1, 0,   0, 0, 0, 6'd0, 0, "wb_over_upd");
    add(1, 0, 0, 0, 0, 0, 6'd0, 1, 1, 0, 0,   1, 0, 0, 6'd0, 0, "alu_upd");
    add(1, 0, 1, 0, 1, 1, 6'd0, 0, 0, 0, 0,   1, 0, 0, 6'd0, 0, "no_grp_aluf");
    add(1, 0, 0, 1, 0, 1, 6'd3, 0, 0, 0, 0,   1, 0, 0, 6'd0, 0, "no_grp_loopf");
    add(1, 1, 0, 1, 0, 1, 6'd3, 0, 0, 0, 0,   1, 0, 1, 6'd3, 1, "load3");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   1, 0, 1, 6'd2, 1, "step_2");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   1, 0, 1, 6'd1, 1, "step_1");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0,   1, 0, 1, 6'd1, 1, "no_step_hold");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   1, 0, 1, 6'd0, 0, "step_done");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   1, 0, 1, 6'd0, 0, "step_in_done");
    add(1, 1, 1, 1, 0, 1, 6'd5, 0, 0, 0, 0,   1, 0, 0, 6'd5, 1, "both_ld5");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   1, 0, 0, 6'd4, 1, "step_4");
    add(0, 1, 1, 1, 1, 1, 6'd7, 1, 1, 1, 1,   0, 0, 0, 6'd0, 0, "reset_mid_run");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   0, 0, 0, 6'd0, 0, "step_in_idle");
    add(1, 1, 0, 1, 0, 0, 6'd0, 0, 0, 0, 0,   0, 0, 1, 6'd0, 0, "load0_done");
    add(1, 1, 0, 1, 0, 0, 6'd5, 0, 0, 0, 0,   0, 0, 0, 6'd5, 1, "load5");
    add(1, 1, 0, 1, 0, 0, 6'd2, 0, 0, 0, 1,   0, 0, 0, 6'd2, 1, "reload_wins");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   0, 0, 0, 6'd1, 1, "rl_step_1");
    add(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1,   0, 0, 1, 6'd0, 0, "rl_step_done");

    foreach (vecs[i]) begin
      drive(vecs[i].rst_l, vecs[i].g, vecs[i].af, vecs[i].lf, vecs[i].w31, vecs[i].w30,
            vecs[i].wcnt, vecs[i].upd, vecs[i].c, vecs[i].so, vecs[i].stp);
      cycle_check(vecs[i].name, {vecs[i].e_alkc, vecs[i].e_aluso, vecs[i].e_flag,
                                 vecs[i].e_busy, vecs[i].e_cnt});
    end

    // Full-range count: load 63 then one step, then a count-1 load finishing on one step.
    drive(1, 1, 0, 1, 0, 0, 6'd63, 0, 0, 0, 0); cycle_check("load63", {3'b000, 1'b1, 6'd63});
    drive(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1);  cycle_check("step_62", {3'b000, 1'b1, 6'd62});
    drive(1, 1, 0, 1, 0, 1, 6'd1, 0, 0, 0, 0);  cycle_check("load1", {3'b001, 1'b1, 6'd1});
    drive(1, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1);  cycle_check("load1_done", {3'b001, 1'b0, 6'd0});
    // Reset overrides a simultaneous ALU flag load.
    drive(0, 1, 1, 0, 1, 1, 6'd0, 0, 0, 0, 0);  cycle_check("reset_vs_load", 10'd0);

    // Randomized traffic against the model (model starts from the reset above).
    model(0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic rst_l, g, af, lf, w31, w30, upd, c, so, stp;
      logic [5:0] wcnt;
      rst_l = ($urandom_range(0, 39) != 0);
      g     = ($urandom_range(0, 3) == 0);
      af    = 1'($urandom);
      lf    = ($urandom_range(0, 2) == 0);
      w31   = 1'($urandom);
      w30   = 1'($urandom);
      wcnt  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 4));
      upd   = 1'($urandom);
      c     = 1'($urandom);
      so    = 1'($urandom);
      stp   = ($urandom_range(0, 2) != 0);
      drive(rst_l, g, af, lf, w31, w30, wcnt, upd, c, so, stp);
      model(rst_l, g, af, lf, w31, w30, wcnt, upd, c, so, stp);
      cycle_check("random", m_outs());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alk_wbus_flag_load.md
ALK_WBUS_FLAG_LOAD -- requirements
Module: alk_wbus_flag_load

Interface
REQ-001 SHALL: clk_h  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset_l  in  1  reset, synchronous, active-low.
REQ-003 SHALL: wbus_in_h  in  32  WBUS data as received by ALK.
REQ-004 SHALL: alpctl_wb_group_ld  in  1  high = ALK group loads from WBUS (ALK WBUS drivers are off).
REQ-005 SHALL: alpctl_wb_aluf_h  in  1  with group_ld, load alkc/aluso flags from WBUS.
REQ-006 SHALL: alpctl_wb_loopf_h  in  1  with group_ld, load loop flag and loop count from WBUS.
REQ-007 SHALL: alu_flag_upd_h  in  1  normal ALU flag update strobe.
REQ-008 SHALL: alu_c_h, alu_so_h  in  1 each  ALU carry and shift-out results.
REQ-009 SHALL: loop_step_h  in  1  one loop iteration completed.
REQ-010 SHALL: alkc_flag_h, aluso_flag_h, loop_flag_h  out  1 each  registered flags.
REQ-011 SHALL: loop_cnt_h  out  6  remaining iteration count.
REQ-012 SHALL: loop_busy_h  out  1  high while loop state = RUN.

Function
REQ-013 SHALL: all outputs are registered; a strobe sampled at edge N is visible after edge N (latency 1).
REQ-014 SHALL: group_ld & aluf: alkc_flag <= wbus_in_h[30], aluso_flag <= wbus_in_h[31].
REQ-015 SHALL: alu_flag_upd_h (absent the REQ-014 load): alkc_flag <= alu_c_h, aluso_flag <= alu_so_h.
REQ-016 SHALL: REQ-014 load takes priority over alu_flag_upd_h in the same cycle.
REQ-017 SHALL: group_ld & aluf & loopf together: alkc_flag <= wbus_in_h[30] (ALU flag takes bit 30 over loop), loop section per REQ-018 still applies.
REQ-018 SHALL: group_ld & loopf: loop_cnt <= wbus_in_h[5:0], loop_flag <= wbus_in_h[30] unless aluf also set (then loop_flag <= 0); next state RUN if count nonzero, else DONE with loop_flag <= 1.
REQ-019 SHALL: loop FSM states IDLE, RUN, DONE; IDLE -> RUN/DONE only via REQ-018 load.
REQ-020 SHALL: RUN with loop_step_h: loop_cnt decrements by 1; when loop_cnt = 1, next loop_cnt = 0, state DONE, loop_flag <= 1.
REQ-021 SHALL: loop_step_h in IDLE or DONE is ignored; count never wraps below 0.
REQ-022 SHALL: loop load and loop_step_h in the same cycle: load wins, step discarded.
REQ-023 SHALL: DONE holds loop_flag = 1 and loop_cnt = 0 until next loop load.
REQ-024 SHALL: group_ld low ignores aluf/loopf entirely.

Reset
REQ-025 SHALL: reset_l low at an edge: all flags 0, loop_cnt 0, state IDLE, loop_busy 0; overrides every other input including a simultaneous load.
REQ-026 SHALL: reset mid-RUN abandons the loop; no DONE transition, loop_flag stays 0.

Structure
REQ-027 SHALL: shared package alk_pkg holds loop state enum (IDLE/RUN/DONE), LOOP_CNT_W = 6, WBUS flag bit positions 31/30.
REQ-028 SHALL: loop counter and FSM form one sub-module alk_loop_ctr; flag registers stay in the top.

Verification
REQ-029 SHALL: reset then group_ld=1, aluf=1, wbus[31:30]=2'b10 -> next cycle aluso=1, alkc=0.
REQ-030 SHALL: same-cycle group_ld&aluf (wbus[30]=0) and alu_flag_upd (alu_c=1) -> alkc=0.
REQ-031 SHALL: loop load count 3, three loop_step pulses -> cnt 2,1,0; DONE and loop_flag=1 after third step; busy falls same edge.
REQ-032 SHALL: loop load count 0 -> DONE, loop_flag=1, busy never asserted.
REQ-033 SHALL: RUN cnt=5, simultaneous reload count 2 and step -> cnt=2, RUN; extra step in DONE -> cnt stays 0.
REQ-034 SHALL: reset_l low during RUN cnt=4 -> next cycle all outputs 0, IDLE.
